// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 opcodes, MDU state encoding and op-class helper.
package riscv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Radix-2 shift-add multiplier / restoring divider on operand magnitudes, with
// sign fix applied to the value the current step produces.
module mdu_datapath
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_fix
);

    logic [2:0]         op_q;
    logic               sa_q;
    logic               sb_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic               a_signed;
    logic               b_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sum;

    always_comb begin
        a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed & a[WIDTH-1];
        b_neg    = b_signed & b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient};
    // both ops load the same way, only the per-step update differs.
    always_comb begin
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, opb_q};
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        if (is_div(op_q)) begin
            if (!trial[WIDTH])
                acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_step = {sum, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -acc_step : acc_step;
        quo      = (sa_q ^ sb_q) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem      = sa_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        if (is_div(op_q))
            res_fix = op_q[1] ? rem : quo;
        else if (op_q == F3_MUL)
            res_fix = prod_fix[WIDTH-1:0];
        else
            res_fix = prod_fix[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            opb_q <= '0;
            acc_q <= '0;
        end else if (load) begin
            op_q  <= funct3;
            sa_q  <= a_neg;
            sb_q  <= b_neg;
            opb_q <= b_mag;
            acc_q <= {{WIDTH{1'b0}}, a_mag};
        end else if (step) begin
            acc_q <= acc_step;
        end
    end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle RV32M multiply/divide unit: handshake FSM, iteration counter and
// fast path for divide-by-zero and signed overflow.
//
// state    | meaning
// MDU_IDLE | ready for a request (in_ready=1)
// MDU_CALC | one radix-2 iteration per cycle, cnt counts down
// MDU_DONE | result held with out_valid=1 until out_ready
module mdu_iterative
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             accept;
    logic             step;
    logic             b_zero;
    logic             ovf;
    logic             fast;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH-1:0] res_fix;

    always_comb begin
        accept   = in_valid && (state_q == MDU_IDLE) && !flush;
        step     = (state_q == MDU_CALC) && !flush;
        b_zero   = (b == '0);
        ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == MIN_VAL) && (b == '1);
        fast     = is_div(funct3) && (b_zero || ovf);
        if (b_zero)
            fast_res = funct3[1] ? a : '1;
        else
            fast_res = funct3[1] ? '0 : MIN_VAL;
    end

    mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .step    (step),
        .funct3  (funct3),
        .a       (a),
        .b       (b),
        .res_fix (res_fix)
    );

    // The last iteration and the sign fix share one edge, giving WIDTH+1 edges
    // from accept to out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state_q     <= MDU_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (in_valid) begin
                        if (fast) begin
                            state_q     <= MDU_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= fast_res;
                        end else begin
                            state_q <= MDU_CALC;
                            cnt_q   <= CNT_W'(WIDTH);
                        end
                    end
                end
                MDU_CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= MDU_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= res_fix;
                    end
                end
                MDU_DONE: begin
                    if (out_ready) begin
                        state_q     <= MDU_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == MDU_IDLE);
    assign busy      = (state_q != MDU_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed RV32M vectors, handshake/flush/reset scenarios
// and a randomized run against a 64-bit arithmetic reference model.
module tb_mdu_iterative;

    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    funct3 = 3'd0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  result;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx, sy, ux, uy, p, q;
        longint unsigned up;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (f3)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin up = longint'(ux) * longint'(uy); return up[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MINV && y == 32'hFFFF_FFFF) return MINV;
                q = sx / sy; return q[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == MINV && y == 32'hFFFF_FFFF) return 32'd0;
                q = sx % sy; return q[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] x,
                                       input logic [31:0] y);
        if (f3[2] && y == 0) return 1;
        if (f3[2] && !f3[0] && x == MINV && y == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return MINV;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Drives one request, returns the captured result and edges from accept
    // (accept edge = 1) to out_valid, then consumes the result after 'hold' cycles.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                          input int hold, output logic [31:0] res, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL run_op_ready_timeout in_ready=%0b required 1", in_ready);
        end
        funct3 = f3; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            errors++;
            $display("FAIL run_op_valid_timeout out_valid=%0b required 1", out_valid);
        end
        res = result;
        repeat (hold) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        #11 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_f3  [11] = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd2, 3'd7};
        logic [31:0] t_a   [11] = '{32'd7, 32'h8000_0000, -32'd7, -32'd7, 32'hFFFF_FFFE, 32'd5,
                                    32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] t_b   [11] = '{-32'd3, 32'h8000_0000, 32'd2, 32'd2, 32'd3, 32'd0, 32'd0,
                                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        logic [31:0] t_exp [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                    32'h5555_5554, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                    32'hFFFF_FFFF, 32'd1};
        int          t_lat [11] = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 33};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            run_op(t_f3[i], t_a[i], t_b[i], 0, res, lat);
            checks++;
            if (res !== t_exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] f3=%0d got %h want %h", i, t_f3[i], res, t_exp[i]);
            end
            checks++;
            if (lat != t_lat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, t_lat[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] x1, y1, e1, x2, y2, e2;
        int          lat;
        bit          ok;
        x1 = $urandom; y1 = $urandom; e1 = ref_model(3'd0, x1, y1);
        x2 = $urandom; y2 = $urandom; e2 = ref_model(3'd3, x2, y2);
        funct3 = 3'd0; a = x1; b = y1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (result !== e1 || !out_valid) begin
            errors++;
            $display("FAIL bp_first_result got %h valid=%0b want %h", result, out_valid, e1);
        end
        funct3 = 3'd3; a = x2; b = y2; in_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result !== e1 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_hold result=%h valid=%0b in_ready=%0b want %h 1 0", result, out_valid, in_ready, e1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready=%0b out_valid=%0b busy=%0b want 1 0 0", in_ready, out_valid, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept busy=%0b in_ready=%0b want 1 0", busy, in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++;
        if (result !== e2 || lat != 33) begin
            errors++;
            $display("FAIL bp_second_op got %h lat %0d want %h lat 33", result, lat, e2);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] x, y, res;
        int          lat;
        for (int i = 0; i < 8; i++) begin
            f3 = 3'(i); x = $urandom; y = $urandom;
            run_op(f3, x, y, 0, res, lat);
            checks++;
            if (res !== ref_model(f3, x, y) || lat != exp_latency(f3, x, y)) begin
                errors++;
                $display("FAIL b2b[%0d] f3=%0d got %h lat %0d want %h lat %0d", i, f3, res, lat,
                         ref_model(f3, x, y), exp_latency(f3, x, y));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int          lat;
        bit          seen;
        funct3 = 3'd0; a = $urandom; b = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc busy=%0b in_ready=%0b out_valid=%0b want 0 1 0", busy, in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_no_output out_valid rose after flush, want 0"); end
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept busy=%0b want 0", busy); end
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, res, lat);
        checks++;
        if (res !== 32'hFFFF_FFFE || lat != 33) begin
            errors++;
            $display("FAIL flush_then_mulhu got %h lat %0d want fffffffe lat 33", res, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] x, y, res;
        int          lat;
        bit          seen;
        funct3 = 3'd4; a = $urandom; b = 32'($urandom_range(1, 1000)); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL async_reset in_ready=%0b out_valid=%0b busy=%0b result=%h want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL async_reset_no_output out_valid rose, want 0"); end
        x = $urandom; y = $urandom;
        run_op(3'd6, x, y, 1, res, lat);
        checks++;
        if (res !== ref_model(3'd6, x, y)) begin
            errors++;
            $display("FAIL async_reset_recover got %h want %h", res, ref_model(3'd6, x, y));
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] x, y, res, e;
        int          lat, el;
        for (int i = 0; i < 1500; i++) begin
            f3 = 3'($urandom_range(0, 7));
            x  = pick_operand();
            y  = pick_operand();
            e  = ref_model(f3, x, y);
            el = exp_latency(f3, x, y);
            run_op(f3, x, y, $urandom_range(0, 3), res, lat);
            checks++;
            if (res !== e || lat != el) begin
                errors++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h got %h lat %0d want %h lat %0d",
                         i, f3, x, y, res, lat, e, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule
